ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits in the EX stage beside the single-cycle ALU of the 5-stage pipeline.
- Parametrised in operand width; accepts one operation, stalls the front of the pipeline while it iterates, then returns one result with its destination register tag.
- Adds multi-cycle execution, an EX-originated stall request, and flush cancellation, none of which the single-cycle EX path has.

Parameters:
- DATA_W, 32, operand/result width (≥ 4, even).
- RF_ADDRESS, 5, destination register tag width.
- CNT_W, $clog2(DATA_W), iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction is an M-op; sampled only in IDLE.
- flush  in  1  branch flush; cancels any in-flight op.
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  DATA_W  rs1 value, already forwarded.
- op_b  in  DATA_W  rs2 value, already forwarded.
- rd_in  in  RF_ADDRESS  destination register.
- stall  out  1  hold PC, IF/ID and ID/EX.
- busy  out  1  state is CALC or FIX.
- done  out  1  result valid (one cycle).
- result  out  DATA_W  operation result.
- rd_out  out  RF_ADDRESS  tag captured at acceptance.

Behaviour:
- FSM states: IDLE, CALC, FIX, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, result=0, rd_out=0, done=0, busy=0.
  - stall=0 while reset is asserted.
- Acceptance edge k (IDLE, start=1, flush=0):
  - Latch func3 and rd_in.
  - Latch |op_a| and |op_b|. The operand is taken as signed only if func3 calls for it: op_a is signed for MULH, MULHSU, DIV, REM; op_b is signed for MULH, DIV, REM.
  - Latch the sign flags.
  - Clear the 2*DATA_W accumulator and the counter.
  - Next state = CALC, except for the early-out cases below.
- Early-out at acceptance (next state = DONE, result loaded on edge k):
  - DIV/DIVU with op_b=0: result = all ones.
  - REM/REMU with op_b=0: result = op_a.
  - DIV with op_a = signed minimum and op_b = -1: result = op_a.
  - REM with the same operands: result = 0.
- CALC, one radix-2 step per edge, counter+1:
  - Multiply: shift-add, unsigned, full 2*DATA_W product.
  - Divide: restoring, unsigned quotient and remainder.
  - The edge on which counter == DATA_W-1 performs the last step and moves to FIX.
- FIX, one edge:
  - Negate the product if the signs differ (MULHSU: sign of op_a only).
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Select the low half (MUL), the high half (MULH*), the quotient, or the remainder into result.
  - Next state = DONE.
- DONE: done=1 and result/rd_out are valid. Next edge goes to IDLE unconditionally; start is ignored in DONE.
- Latency:
  - Normal ops: done is sampled high at edge k+DATA_W+2.
  - Early-out: done is sampled high at edge k+1.
- stall (combinational):
  - High in CALC and FIX.
  - High in IDLE when start=1 and flush=0.
  - Low in DONE, so ID/EX and EX/MEM advance on the edge that captures result.
- result and rd_out hold their values after DONE until the next FIX or early-out load.
- flush:
  - In any state, next state = IDLE; done stays 0; result unchanged.
  - Flush has priority over start and over DONE→IDLE.
  - When flush and start are both high in IDLE, nothing is accepted.
- Reset mid-operation: immediate return to the reset values; no residual done after reset release.
- Arithmetic is mod 2^DATA_W. No exceptions; divide-by-zero and overflow follow RV32M.

Test Plan (DATA_W=32):
1. MUL 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB, rd_out = rd_in. done is high exactly one cycle, sampled at edge k+34. stall is high from acceptance until done.
2. Signed/unsigned high-half products:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. Division sign rules, op_a = 0xFFFFFFF9 (-7), op_b = 2:
   - DIV → 0xFFFFFFFD.
   - REM → 0xFFFFFFFF.
   - DIVU → 0x7FFFFFFC.
   - REMU → 1.
4. Early-out cases, each with done at k+1 and stall high only in the acceptance cycle:
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0.
5. Flush and restart:
   - Assert flush in the 10th CALC cycle → state IDLE next edge, busy=0, stall=0, no done pulse.
   - Start a new MUL 3×4 on the following cycle → result 12 at +34.
6. Reset and concurrent controls:
   - Drive reset low mid-CALC → done/busy/stall/result/rd_out go to 0 without waiting for a clock edge.
   - After release, DIV 100/7 → 14.
   - start and flush high together in IDLE → nothing accepted.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// One radix-2 step per cycle (shift-add multiply, restoring divide), a
// sign-fix cycle, then a one-cycle done with the captured destination tag.
// Stalls the front of the pipeline while busy; flush cancels any op.
module ex_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            func3,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [RF_ADDRESS-1:0] rd_in,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic [RF_ADDRESS-1:0] rd_out
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              func3_q;
    logic [RF_ADDRESS-1:0]   rd_q;
    logic                    sign_a, sign_b;
    logic [DATA_W-1:0]       mag_a, mag_b;
    logic [2*DATA_W-1:0]     acc;

    logic                    signed_a, signed_b, div_zero, div_ovf, early, accept, last;
    logic [DATA_W-1:0]       early_res, fix_res, quo, rem;
    logic [2*DATA_W-1:0]     prod;
    logic [DATA_W:0]         mul_sum, div_shift, div_diff;
    logic                    div_ok;

    // Magnitude of a possibly-signed operand (two's-complement minimum maps to itself)
    function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v, input logic is_signed);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return (is_signed && sv < 0) ? DATA_W'(-sv) : v;
    endfunction

    // Conditional negate, single width
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    // Conditional negate, double width
    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? (~v + (2*DATA_W)'(1)) : v;
    endfunction

    // Operand decode, early-out detection and the per-step arithmetic
    always_comb begin
        signed_a  = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
        signed_b  = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        div_zero  = func3[2] && (op_b == '0);
        div_ovf   = func3[2] && !func3[0] && (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
        early     = div_zero || div_ovf;
        if (div_zero) early_res = func3[1] ? op_a : '1;
        else          early_res = func3[1] ? '0 : op_a;
        accept    = (state == S_IDLE) && start && !flush;
        last      = (cnt == CNT_W'(DATA_W-1));

        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc[2*DATA_W-1:DATA_W], mag_a[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ok    = !div_diff[DATA_W];

        prod = neg_2w(acc, sign_a ^ sign_b);
        quo  = neg_w(acc[DATA_W-1:0], sign_a ^ sign_b);
        rem  = neg_w(acc[2*DATA_W-1:DATA_W], sign_a);
        case (func3_q)
            3'b000:                 fix_res = prod[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = early ? S_DONE : S_CALC;
                S_CALC:  if (last) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register, iteration counter and the visible result/tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept)                cnt <= '0;
            else if (state == S_CALC)  cnt <= cnt + CNT_W'(1);
            if (accept && early) begin
                result <= early_res;
                rd_out <= rd_in;
            end else if (state == S_FIX && !flush) begin
                result <= fix_res;
                rd_out <= rd_q;
            end
        end
    end

    // Datapath: operand capture at acceptance, then one radix-2 step per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            func3_q <= func3;
            rd_q    <= rd_in;
            sign_a  <= signed_a && op_a[DATA_W-1];
            sign_b  <= signed_b && op_b[DATA_W-1];
            mag_a   <= mag_of(op_a, signed_a);
            mag_b   <= mag_of(op_b, signed_b);
            acc     <= '0;
        end else if (state == S_CALC) begin
            if (!func3_q[2]) begin
                acc   <= {mul_sum, acc[DATA_W-1:1]};
                mag_b <= mag_b >> 1;
            end else begin
                acc[2*DATA_W-1:DATA_W] <= div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                acc[DATA_W-1:0]        <= {acc[DATA_W-2:0], div_ok};
                mag_a                  <= mag_a << 1;
            end
        end
    end

    // Status outputs; stall is forced low while reset is asserted
    always_comb begin
        busy  = (state == S_CALC) || (state == S_FIX);
        done  = (state == S_DONE);
        stall = reset && (busy || accept);
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for the iterative multiply/divide unit.
module tb_ex_muldiv_unit;

    localparam int DATA_W   = 32;
    localparam int LAT_NORM = DATA_W + 1;  // edges after acceptance until done is seen

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              flush = 1'b0;
    logic [2:0]        func3 = 3'b000;
    logic [31:0]       op_a = '0;
    logic [31:0]       op_b = '0;
    logic [4:0]        rd_in = '0;
    logic              stall, busy, done;
    logic [31:0]       result;
    logic [4:0]        rd_out;

    int n_chk = 0;
    int n_err = 0;

    ex_muldiv_unit #(.DATA_W(DATA_W), .RF_ADDRESS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .stall(stall), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at the current point (just after a rising edge), follow it to done
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int   cycles;
        logic stall_low;
        start = 1'b1; func3 = f3; op_a = a; op_b = b; rd_in = rd;
        #1;
        check_eq({tag, "_acc_stall"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        stall_low = 1'b0;
        while (!done && cycles < 100) begin
            if (!stall) stall_low = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check_eq({tag, "_stall_busy"}, 32'(stall_low), 32'd0);
        check_eq({tag, "_result"}, result, exp);
        check_eq({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check_eq({tag, "_stall_done"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, result, exp);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check_eq("rst_done",   32'(done),   32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_stall",  32'(stall),  32'd0);
        check_eq("rst_result", result,      32'd0);
        check_eq("rst_rd",     32'(rd_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd11, 32'hFFFFFFEB, LAT_NORM);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000, LAT_NORM);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, LAT_NORM);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFF, LAT_NORM);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd15, 32'hFFFFFFFD, LAT_NORM);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd16, 32'hFFFFFFFF, LAT_NORM);
        run_op("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        5'd17, 32'h7FFFFFFC, LAT_NORM);
        run_op("remu",   3'b111, 32'hFFFFFFF9, 32'd2,        5'd18, 32'd1,        LAT_NORM);
        run_op("divu0",  3'b101, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 0);
        run_op("rem0",   3'b110, 32'd5,        32'd0,        5'd20, 32'd5,        0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        0);

        // Flush in the 10th CALC cycle
        start = 1'b1; func3 = 3'b000; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_busy",   32'(busy),  32'd0);
        check_eq("flush_stall",  32'(stall), 32'd0);
        check_eq("flush_done",   32'(done),  32'd0);
        check_eq("flush_result", result,     32'd0);
        flush = 1'b0;
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd5, 32'd12, LAT_NORM);

        // Asynchronous reset mid-CALC
        start = 1'b1; func3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_done",   32'(done),   32'd0);
        check_eq("arst_busy",   32'(busy),   32'd0);
        check_eq("arst_stall",  32'(stall),  32'd0);
        check_eq("arst_result", result,      32'd0);
        check_eq("arst_rd",     32'(rd_out), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_no_done", 32'(done), 32'd0);
        run_op("div_after_rst", 3'b100, 32'd100, 32'd7, 5'd3, 32'd14, LAT_NORM);

        // start and flush together in IDLE: nothing is accepted
        start = 1'b1; flush = 1'b1; func3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd7;
        #1;
        check_eq("sf_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check_eq("sf_busy", 32'(busy), 32'd0);
        check_eq("sf_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("sf_idle_busy", 32'(busy), 32'd0);
        check_eq("sf_result",    result,    32'd14);
        check_eq("sf_rd",        32'(rd_out), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
